// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - three-requester round-robin arbiter in front of a UART serializer (optional stall timeout: UART_TX_ARB_TIMEOUT_EN)
module uart_tx_arbiter #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    input  logic       req2_valid,
    input  logic [7:0] req2_data,
    input  logic       req2_last,
    output logic       req2_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    output logic [1:0] grant,
    output logic       busy,
    output logic       timeout_evt
);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t     state, state_nx;
    logic [1:0] owner, owner_nx;
    logic [1:0] last_owner, last_owner_nx;
    logic [1:0] pick;
    logic [2:0] req_valid;
    logic       own_valid;
    logic       own_last;
    logic [7:0] own_data;
    logic       active;
    logic       fire;
    logic       timeout_hit;

    assign req_valid = {req2_valid, req1_valid, req0_valid};

    // The owner only drives the serializer outside reset, so a byte presented
    // in the reset cycle is never handshaken.
    assign active = (state == XFER) && rst;
    assign fire   = tx_valid && tx_ready;

    // Select the current owner's request signals.
    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = 8'h00;
        case (owner)
            2'd0: begin own_valid = req0_valid; own_last = req0_last; own_data = req0_data; end
            2'd1: begin own_valid = req1_valid; own_last = req1_last; own_data = req1_data; end
            2'd2: begin own_valid = req2_valid; own_last = req2_last; own_data = req2_data; end
            default: ;
        endcase
    end

    // Round-robin search starting just after the previous owner.
    always_comb begin
        pick = 2'd0;
        case (last_owner)
            2'd0:    pick = req_valid[1] ? 2'd1 : (req_valid[2] ? 2'd2 : 2'd0);
            2'd1:    pick = req_valid[2] ? 2'd2 : (req_valid[0] ? 2'd0 : 2'd1);
            default: pick = req_valid[0] ? 2'd0 : (req_valid[1] ? 2'd1 : 2'd2);
        endcase
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] stall_cnt;

    assign timeout_hit = active && !own_valid && (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout_evt = timeout_hit;

    // Count consecutive owner-idle cycles; any presented byte restarts the count.
    always_ff @(posedge clk) begin
        if (!rst || state != XFER || own_valid || timeout_hit)
            stall_cnt <= '0;
        else
            stall_cnt <= stall_cnt + 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
    // Tied low; the comparison is constant false for any legal TIMEOUT_CYCLES.
    assign timeout_evt = (TIMEOUT_CYCLES < 0);
`endif

    // State, owner and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= 2'd0;
            last_owner <= 2'd2;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            last_owner <= last_owner_nx;
        end
    end

    // Next-state: grant on any request, release on last byte or timeout.
    always_comb begin
        state_nx      = state;
        owner_nx      = owner;
        last_owner_nx = last_owner;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    state_nx = XFER;
                    owner_nx = pick;
                end
            end
            XFER: begin
                if ((fire && own_last) || timeout_hit) begin
                    state_nx      = IDLE;
                    last_owner_nx = owner;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Combinational pass-through from the owner to the serializer.
    always_comb begin
        tx_valid   = active && own_valid;
        tx_data    = tx_valid ? own_data : 8'h00;
        req0_ready = active && (owner == 2'd0) && tx_ready;
        req1_ready = active && (owner == 2'd1) && tx_ready;
        req2_ready = active && (owner == 2'd2) && tx_ready;
        grant      = active ? owner : 2'd3;
        busy       = active;
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter (timeout scenario under UART_TX_ARB_TIMEOUT_EN)
module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0, req2_valid = 1'b0;
    logic [7:0] req0_data = 8'h00, req1_data = 8'h00, req2_data = 8'h00;
    logic       req0_last = 1'b0, req1_last = 1'b0, req2_last = 1'b0;
    logic       req0_ready, req1_ready, req2_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready = 1'b0;
    logic [1:0] grant;
    logic       busy;
    logic       timeout_evt;

    int checks = 0;
    int errors = 0;
    logic [7:0] rx_q[$];

    uart_tx_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
        .req2_valid(req2_valid), .req2_data(req2_data), .req2_last(req2_last), .req2_ready(req2_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .grant(grant), .busy(busy), .timeout_evt(timeout_evt)
    );

    always #5 clk = ~clk;

    // Record every byte handshaken with the serializer.
    always @(negedge clk) begin
        if (rst && tx_valid && tx_ready) rx_q.push_back(tx_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_valid(input int n, input logic v);
        case (n)
            0: req0_valid = v;
            1: req1_valid = v;
            default: req2_valid = v;
        endcase
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; req2_valid = 1'b0;
        req0_last = 1'b0; req1_last = 1'b0; req2_last = 1'b0;
        tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        rx_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0; req0_valid = 1'b1; tx_ready = 1'b1;
        tick();
        #1;
        checks++; if (grant !== 2'd3) begin errors++; $display("FAIL reset_grant: got %0d want 3", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_req0_ready: got %b want 0", req0_ready); end
        checks++; if (timeout_evt !== 1'b0) begin errors++; $display("FAIL reset_timeout_evt: got %b want 0", timeout_evt); end
        do_reset();
    endtask

    task automatic test_single_msg();
        logic [7:0] exp [3] = '{8'h41, 8'h42, 8'h43};
        req1_valid = 1'b1; req1_data = 8'h41; req1_last = 1'b0; tx_ready = 1'b1;
        #1;
        checks++; if (grant !== 2'd3 || req1_ready !== 1'b0) begin errors++; $display("FAIL single_idle: grant %0d ready %b want 3 0", grant, req1_ready); end
        for (int k = 0; k < 3; k++) begin
            tick();
            req1_data = exp[k]; req1_last = (k == 2);
            #1;
            checks++; if (grant !== 2'd1) begin errors++; $display("FAIL single_grant%0d: got %0d want 1", k, grant); end
            checks++; if (tx_data !== exp[k] || tx_valid !== 1'b1 || req1_ready !== 1'b1) begin errors++; $display("FAIL single_byte%0d: data %h valid %b ready %b want %h 1 1", k, tx_data, tx_valid, req1_ready, exp[k]); end
        end
        tick();
        req1_valid = 1'b0; req1_last = 1'b0;
        #1;
        checks++; if (grant !== 2'd3 || busy !== 1'b0) begin errors++; $display("FAIL single_end: grant %0d busy %b want 3 0", grant, busy); end
        checks++;
        if (rx_q.size() != 3) begin errors++; $display("FAIL single_count: got %0d want 3", rx_q.size()); end
        else for (int i = 0; i < 3; i++) begin
            checks++; if (rx_q[i] !== exp[i]) begin errors++; $display("FAIL single_rx%0d: got %h want %h", i, rx_q[i], exp[i]); end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        req0_valid = 1'b1; req1_valid = 1'b1; req2_valid = 1'b1;
        req0_data = 8'hA0; req1_data = 8'hA1; req2_data = 8'hA2;
        req0_last = 1'b1; req1_last = 1'b1; req2_last = 1'b1; tx_ready = 1'b1;
        #1;
        checks++; if (grant !== 2'd3) begin errors++; $display("FAIL rr_idle: got %0d want 3", grant); end
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            checks++; if (grant !== 2'(i) || tx_data !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL rr_grant%0d: grant %0d data %h want %0d %h", i, grant, tx_data, i, 8'hA0 + 8'(i)); end
            checks++; if ({req2_ready, req1_ready, req0_ready} !== 3'(1 << i)) begin errors++; $display("FAIL rr_ready%0d: got %b want %b", i, {req2_ready, req1_ready, req0_ready}, 3'(1 << i)); end
            tick();
            set_valid(i, 1'b0);
            #1;
            checks++; if (grant !== 2'd3 || tx_valid !== 1'b0) begin errors++; $display("FAIL rr_bubble%0d: grant %0d valid %b want 3 0", i, grant, tx_valid); end
        end
        req0_last = 1'b0; req1_last = 1'b0; req2_last = 1'b0;
    endtask

    task automatic test_no_interleave();
        req0_valid = 1'b1; req0_data = 8'hB0; req0_last = 1'b0;
        req2_valid = 1'b1; req2_data = 8'hC0; req2_last = 1'b1; tx_ready = 1'b1;
        rx_q.delete();
        tick();
        for (int k = 0; k < 4; k++) begin
            req0_data = 8'hB0 + 8'(k); req0_last = (k == 3);
            #1;
            checks++; if (grant !== 2'd0 || tx_data !== 8'hB0 + 8'(k) || req2_ready !== 1'b0) begin errors++; $display("FAIL ni_byte%0d: grant %0d data %h r2 %b want 0 %h 0", k, grant, tx_data, req2_ready, 8'hB0 + 8'(k)); end
            tick();
        end
        req0_valid = 1'b0; req0_last = 1'b0;
        #1;
        checks++; if (grant !== 2'd3) begin errors++; $display("FAIL ni_bubble: got %0d want 3", grant); end
        tick();
        #1;
        checks++; if (grant !== 2'd2 || tx_data !== 8'hC0) begin errors++; $display("FAIL ni_req2: grant %0d data %h want 2 c0", grant, tx_data); end
        tick();
        req2_valid = 1'b0; req2_last = 1'b0;
        #1;
        checks++; if (rx_q.size() != 5 || rx_q[3] !== 8'hB3 || rx_q[4] !== 8'hC0) begin errors++; $display("FAIL ni_order: count %0d want 5 ending b3 c0", rx_q.size()); end
    endtask

    task automatic test_stall();
        logic [7:0] exp [3] = '{8'hD0, 8'hD1, 8'hD2};
        rx_q.delete();
        req1_valid = 1'b1; req1_data = 8'hD0; req1_last = 1'b0; tx_ready = 1'b1;
        tick();
        #1;
        checks++; if (grant !== 2'd1 || tx_data !== 8'hD0) begin errors++; $display("FAIL stall_first: grant %0d data %h want 1 d0", grant, tx_data); end
        tick();
        req1_data = 8'hD1; tx_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            #1;
            checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hD1 || req1_ready !== 1'b0) begin errors++; $display("FAIL stall_hold%0d: valid %b data %h ready %b want 1 d1 0", i, tx_valid, tx_data, req1_ready); end
            tick();
        end
        tx_ready = 1'b1;
        #1;
        checks++; if (req1_ready !== 1'b1 || tx_data !== 8'hD1) begin errors++; $display("FAIL stall_resume: ready %b data %h want 1 d1", req1_ready, tx_data); end
        tick();
        req1_data = 8'hD2; req1_last = 1'b1;
        tick();
        req1_valid = 1'b0; req1_last = 1'b0;
        #1;
        checks++;
        if (rx_q.size() != 3) begin errors++; $display("FAIL stall_count: got %0d want 3", rx_q.size()); end
        else for (int i = 0; i < 3; i++) begin
            checks++; if (rx_q[i] !== exp[i]) begin errors++; $display("FAIL stall_rx%0d: got %h want %h", i, rx_q[i], exp[i]); end
        end
    endtask

`ifdef UART_TX_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int pulses = 0;
        do_reset();
        req1_valid = 1'b1; req1_data = 8'hF0; req1_last = 1'b0; tx_ready = 1'b1;
        tick();
        tick();
        req1_valid = 1'b0;
        req2_valid = 1'b1; req2_data = 8'hF5; req2_last = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            #1;
            if (timeout_evt === 1'b1) pulses++;
            checks++; if (timeout_evt !== (i == 16) || grant !== 2'd1) begin errors++; $display("FAIL to_stall%0d: evt %b grant %0d want %b 1", i, timeout_evt, grant, (i == 16)); end
            tick();
        end
        #1;
        checks++; if (grant !== 2'd3 || timeout_evt !== 1'b0 || pulses != 1) begin errors++; $display("FAIL to_release: grant %0d evt %b pulses %0d want 3 0 1", grant, timeout_evt, pulses); end
        tick();
        #1;
        checks++; if (grant !== 2'd2 || tx_data !== 8'hF5) begin errors++; $display("FAIL to_next: grant %0d data %h want 2 f5", grant, tx_data); end
        tick();
        req2_valid = 1'b0; req2_last = 1'b0;
    endtask
`else
    task automatic test_hold();
        do_reset();
        req1_valid = 1'b1; req1_data = 8'hF0; req1_last = 1'b0; tx_ready = 1'b1;
        tick();
        tick();
        req1_valid = 1'b0;
        req2_valid = 1'b1; req2_data = 8'hF5; req2_last = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            #1;
            checks++; if (timeout_evt !== 1'b0 || grant !== 2'd1) begin errors++; $display("FAIL hold%0d: evt %b grant %0d want 0 1", i, timeout_evt, grant); end
            tick();
        end
        req1_valid = 1'b1; req1_data = 8'hF1; req1_last = 1'b1;
        #1;
        checks++; if (grant !== 2'd1 || tx_data !== 8'hF1) begin errors++; $display("FAIL hold_last: grant %0d data %h want 1 f1", grant, tx_data); end
        tick();
        req1_valid = 1'b0; req1_last = 1'b0;
        tick();
        #1;
        checks++; if (grant !== 2'd2 || tx_data !== 8'hF5) begin errors++; $display("FAIL hold_next: grant %0d data %h want 2 f5", grant, tx_data); end
        tick();
        req2_valid = 1'b0; req2_last = 1'b0;
    endtask
`endif

    task automatic test_reset_mid();
        do_reset();
        req0_valid = 1'b1; req0_data = 8'hE0; req0_last = 1'b0;
        req1_valid = 1'b1; req1_data = 8'h99; req1_last = 1'b1; tx_ready = 1'b1;
        tick();
        #1;
        checks++; if (grant !== 2'd0 || tx_data !== 8'hE0) begin errors++; $display("FAIL rm_first: grant %0d data %h want 0 e0", grant, tx_data); end
        tick();
        req0_data = 8'hE1; rst = 1'b0;
        #1;
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL rm_no_accept: got %b want 0", req0_ready); end
        tick();
        #1;
        checks++; if (grant !== 2'd3 || busy !== 1'b0 || tx_valid !== 1'b0) begin errors++; $display("FAIL rm_after: grant %0d busy %b valid %b want 3 0 0", grant, busy, tx_valid); end
        rst = 1'b1;
        tick();
        #1;
        checks++; if (grant !== 2'd0 || tx_data !== 8'hE1) begin errors++; $display("FAIL rm_rewin: grant %0d data %h want 0 e1", grant, tx_data); end
        checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'hE0) begin errors++; $display("FAIL rm_count: count %0d want 1 (e0)", rx_q.size()); end
        req0_valid = 1'b0; req1_valid = 1'b0; req1_last = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_msg();
        test_round_robin();
        test_no_interleave();
        test_stall();
`ifdef UART_TX_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_hold();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
